dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the core's load/store port. It gives data memory a valid/ready request-response handshake, programmable wait states, and RISC-V byte/half/word access semantics.
- It sits between the core's data-access initiator and a word-organised RAM array.
- It performs lane selection, sign/zero extension and error detection for misaligned, out-of-range and illegal accesses.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array; legal byte addresses are 0 .. 4*DEPTH_WORDS-1.
- WAIT_STATES, 2: extra cycles between request acceptance and the response; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- req_valid  input  1  initiator presents a request
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- req_funct3  input  3  RISC-V funct3 access size/sign code
- rsp_valid  output  1  response available
- rsp_ready  input  1  initiator accepts the response
- rsp_rdata  output  32  load data, extended to 32 bits; 0 for stores and errors
- rsp_err  output  1  access faulted; no memory side effect occurred

Behaviour:
- Reset (reset_n low, asynchronous):
  - FSM goes to IDLE, wait counter to 0.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Array contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid&&req_ready, latch we/addr/wdata/funct3. Go to WAIT if WAIT_STATES>0, else RESP. Load counter with WAIT_STATES-1.
  - WAIT: req_ready=0. Counter decrements each cycle; at 0, go to RESP.
  - RESP: rsp_valid=1; rsp_rdata/rsp_err held stable. On rsp_ready, go to IDLE. No request is accepted in the same cycle the response is consumed.
- Latency: rsp_valid rises exactly WAIT_STATES+1 cycles after the accepting edge. Back-to-back throughput is one access per WAIT_STATES+2 cycles when rsp_ready is held high.
- Memory commit:
  - Stores write the array on the edge entering RESP, only when no error.
  - Loads read the array on the same edge into a registered rsp_rdata.
- funct3 decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Lane rules:
  - Byte: lane = addr[1:0].
  - Half: lane pair = addr[1].
  - Store writes only the addressed lanes using req_wdata[7:0] or [15:0]; other bytes are preserved.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Error conditions (rsp_err=1, rsp_rdata=0, no write):
  - Half access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - addr[31:2] >= DEPTH_WORDS.
  - Load funct3 in {011,110,111}.
  - Store funct3 not in {000,001,010}.
- Errors follow the same latency as good accesses; there is no early response.
- Input changes on req_* while req_ready=0 are ignored, since all request fields are latched at acceptance.
- Reset asserted in WAIT: request aborted, store not committed. Reset asserted in RESP: response dropped, committed store remains.
- rsp_ready held high with no response pending has no effect.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10, WAIT_STATES=2 -> each rsp_valid 3 cycles after accept; load rsp_rdata=0xDEADBEEF, rsp_err=0.
- After the above: SB 0x55 @0x11, then LB @0x11 -> 0x00000055. LW @0x10 -> 0xDEAD55EF. LBU @0x13 -> 0x000000DE. LB @0x13 -> 0xFFFFFFDE.
- SH 0x8001 @0x22, then LH @0x22 -> 0xFFFF8001; LHU @0x22 -> 0x00008001; word @0x20 low half unchanged.
- LW @0x12, SH @0x21, LW @4*DEPTH_WORDS, load funct3=011 -> each response rsp_err=1, rsp_rdata=0. Follow-up LW @0x10 shows no memory change.
- Response backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stable; req_ready=0 throughout; IDLE entered the cycle after rsp_ready=1.
- Reset abort: SW 0x12345678 @0x30 accepted, reset_n pulsed low during WAIT -> outputs return to reset values immediately. Subsequent LW @0x30 returns the prior contents. Repeat with WAIT_STATES=0 and check rsp_valid one cycle after accept.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the core's
// data-access initiator and the dmem responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory with valid/ready handshake,
// wait states, RISC-V lane select and fault detection.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input logic           clk,
  input logic           reset_n,
  dmem_responder_if.slave bus
);
  localparam int AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_RESP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
  } req_t;

  state_t      state, state_nx;
  logic [3:0]  cnt;
  req_t        held, live, cur;
  logic        accept, commit;
  logic        is_b, is_h, is_w;
  logic        bad_fn, misal, oor, err;
  logic [AW-1:0] idx;
  logic [1:0]  lane;
  logic [31:0] word, ld, wd;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [3:0]  be;

  logic [31:0] mem [DEPTH_WORDS];

  assign accept = bus.req_valid && bus.req_ready;

  assign live = '{
    we:    bus.req_we,
    addr:  bus.req_addr,
    wdata: bus.req_wdata,
    f3:    bus.req_funct3
  };

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (accept)
          state_nx = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT:
        if (cnt == 4'd0) state_nx = S_RESP;
      S_RESP:
        if (bus.rsp_ready) state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == S_IDLE);
    bus.rsp_valid = (state == S_RESP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= 4'd0;
      held <= '0;
    end else if (accept) begin
      cnt  <= 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
      held <= live;
    end else if (state == S_WAIT && cnt != 4'd0) begin
      cnt  <= cnt - 4'd1;
    end
  end

  // With zero wait states the accepting edge is also the commit edge.
  assign cur    = (state == S_IDLE) ? live : held;
  assign commit = (state != S_RESP) && (state_nx == S_RESP);

  always_comb begin
    is_b   = (cur.f3[1:0] == 2'b00);
    is_h   = (cur.f3[1:0] == 2'b01);
    is_w   = (cur.f3[1:0] == 2'b10);
    bad_fn = cur.we ?
      (cur.f3[2] || cur.f3[1:0] == 2'b11) :
      (cur.f3 == 3'b011 || cur.f3[2:1] == 2'b11);
    misal  = (is_h && cur.addr[0]) ||
             (is_w && cur.addr[1:0] != 2'b00);
    oor    = (cur.addr[31:2] >= 30'(DEPTH_WORDS));
    err    = bad_fn || misal || oor;
  end

  assign idx  = cur.addr[AW+1:2];
  assign lane = cur.addr[1:0];
  assign word = mem[idx];
  assign bsel = 8'(word >> {lane, 3'b000});
  assign hsel = cur.addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    ld = '0;
    be = '0;
    wd = '0;
    unique case (1'b1)
      is_b: begin
        ld = cur.f3[2] ? {24'h0, bsel} :
                         {{24{bsel[7]}}, bsel};
        be = 4'b0001 << lane;
        wd = {4{cur.wdata[7:0]}};
      end
      is_h: begin
        ld = cur.f3[2] ? {16'h0, hsel} :
                         {{16{hsel[15]}}, hsel};
        be = cur.addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{cur.wdata[15:0]}};
      end
      is_w: begin
        ld = word;
        be = 4'b1111;
        wd = cur.wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else if (commit) begin
      bus.rsp_err   <= err;
      bus.rsp_rdata <= (err || cur.we) ? 32'h0 : ld;
    end
  end

  // Array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (commit && cur.we && !err) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: u0 with two wait states, u1 with none.
module tb_dmem_responder;
  localparam int WS0 = 2;
  localparam int WS1 = 0;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001;
  localparam logic [2:0] LW = 3'b010, LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  v, wev, rr, rqr, rvv, rev;
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic [31:0] rd [2];
  logic [2:0]  f3 [2];

  exp_t q0 [$];
  exp_t q1 [$];
  exp_t e0, e1;
  int n_cmp = 0;
  int n_bad = 0;

  dmem_responder_if b0 ();
  dmem_responder_if b1 ();

  assign b0.req_valid  = v[0];
  assign b0.req_we     = wev[0];
  assign b0.req_addr   = ad[0];
  assign b0.req_wdata  = wd[0];
  assign b0.req_funct3 = f3[0];
  assign b0.rsp_ready  = rr[0];
  assign b1.req_valid  = v[1];
  assign b1.req_we     = wev[1];
  assign b1.req_addr   = ad[1];
  assign b1.req_wdata  = wd[1];
  assign b1.req_funct3 = f3[1];
  assign b1.rsp_ready  = rr[1];
  assign rqr = {b1.req_ready, b0.req_ready};
  assign rvv = {b1.rsp_valid, b0.rsp_valid};
  assign rev = {b1.rsp_err, b0.rsp_err};
  assign rd[0] = b0.rsp_rdata;
  assign rd[1] = b1.rsp_rdata;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(WS0)) u0 (
    .clk(clk), .reset_n(reset_n), .bus(b0)
  );
  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(WS1)) u1 (
    .clk(clk), .reset_n(reset_n), .bus(b1)
  );

  function automatic void chk(string nm, logic [31:0] got,
                              logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (reset_n && rvv[0] && rr[0]) begin
      if (q0.size() == 0) begin
        chk("unexpected_rsp0", 32'd1, 32'd0);
      end else begin
        e0 = q0.pop_front();
        chk("rdata0", rd[0], e0.d);
        chk("err0", 32'(rev[0]), 32'(e0.e));
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && rvv[1] && rr[1]) begin
      if (q1.size() == 0) begin
        chk("unexpected_rsp1", 32'd1, 32'd0);
      end else begin
        e1 = q1.pop_front();
        chk("rdata1", rd[1], e1.d);
        chk("err1", 32'(rev[1]), 32'(e1.e));
      end
    end
  end

  task automatic send(input int d, input logic we,
                      input logic [31:0] a, input logic [31:0] w,
                      input logic [2:0] f, input logic [31:0] xd,
                      input logic xe, input bit push);
    exp_t x;
    int k;
    @(posedge clk); #1;
    k = 0;
    while (!rqr[d] && k < 40) begin
      @(posedge clk); #1; k++;
    end
    chk("req_ready_idle", 32'(rqr[d]), 32'd1);
    x.d = xd;
    x.e = xe;
    if (push) begin
      if (d == 0) q0.push_back(x);
      else        q1.push_back(x);
    end
    v[d] = 1'b1; wev[d] = we; ad[d] = a;
    wd[d] = w; f3[d] = f;
    @(posedge clk); #1;
    v[d] = 1'b0; wev[d] = ~we; ad[d] = 32'hFFFF_FFFC;
    wd[d] = 32'h0; f3[d] = 3'b111;
  endtask

  task automatic wait_valid(input int d);
    int n;
    n = 1;
    while (!rvv[d] && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", n, (d == 0) ? WS0 + 1 : WS1 + 1);
  endtask

  task automatic drain(input int d);
    int m;
    m = 0;
    while (rvv[d] && m < 40) begin
      @(posedge clk); #1; m++;
    end
    chk("drained", 32'(rvv[d]), 32'd0);
  endtask

  task automatic issue(input int d, input logic we,
                       input logic [31:0] a, input logic [31:0] w,
                       input logic [2:0] f, input logic [31:0] xd,
                       input logic xe);
    send(d, we, a, w, f, xd, xe, 1'b1);
    wait_valid(d);
    drain(d);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(rqr[0]), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rvv[0]), 32'd0);
    chk({tag, "_rsp_rdata"}, rd[0], 32'd0);
    chk({tag, "_rsp_err"}, 32'(rev[0]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    v = '0; wev = '0; rr = 2'b11;
    for (int i = 0; i < 2; i++) begin
      ad[i] = '0; wd[i] = '0; f3[i] = '0;
    end
    #12;
    chk_reset_vals("reset");
    #5 reset_n = 1'b1;

    issue(0, 1, 32'h10, 32'hDEADBEEF, LW, 32'h0, 0);
    issue(0, 0, 32'h10, 32'h0, LW, 32'hDEADBEEF, 0);
    issue(0, 1, 32'h11, 32'hFFFFFF55, LB, 32'h0, 0);
    issue(0, 0, 32'h11, 32'h0, LB, 32'h00000055, 0);
    issue(0, 0, 32'h10, 32'h0, LW, 32'hDEAD55EF, 0);
    issue(0, 0, 32'h13, 32'h0, LBU, 32'h000000DE, 0);
    issue(0, 0, 32'h13, 32'h0, LB, 32'hFFFFFFDE, 0);

    issue(0, 1, 32'h20, 32'h01234567, LW, 32'h0, 0);
    issue(0, 1, 32'h22, 32'hABCD8001, LH, 32'h0, 0);
    issue(0, 0, 32'h22, 32'h0, LH, 32'hFFFF8001, 0);
    issue(0, 0, 32'h22, 32'h0, LHU, 32'h00008001, 0);
    issue(0, 0, 32'h20, 32'h0, LH, 32'h00004567, 0);
    issue(0, 0, 32'h20, 32'h0, LW, 32'h80014567, 0);

    issue(0, 0, 32'h12, 32'h0, LW, 32'h0, 1);
    issue(0, 1, 32'h21, 32'hFFFFFFFF, LH, 32'h0, 1);
    issue(0, 0, 32'h1000, 32'h0, LW, 32'h0, 1);
    issue(0, 0, 32'h10, 32'h0, 3'b011, 32'h0, 1);
    issue(0, 1, 32'h10, 32'h0, 3'b100, 32'h0, 1);
    issue(0, 1, 32'h1000, 32'h0, LW, 32'h0, 1);
    issue(0, 0, 32'h10, 32'h0, LW, 32'hDEAD55EF, 0);

    rr[0] = 1'b0;
    send(0, 0, 32'h10, 32'h0, LW, 32'hDEAD55EF, 0, 1'b1);
    wait_valid(0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(rvv[0]), 32'd1);
      chk("bp_rdata", rd[0], 32'hDEAD55EF);
      chk("bp_err", 32'(rev[0]), 32'd0);
      chk("bp_req_ready", 32'(rqr[0]), 32'd0);
    end
    rr[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle", 32'(rqr[0]), 32'd1);
    chk("bp_valid_low", 32'(rvv[0]), 32'd0);

    issue(0, 1, 32'h30, 32'hCAFEF00D, LW, 32'h0, 0);
    send(0, 1, 32'h30, 32'h12345678, LW, 32'h0, 0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("abort");
    #2 reset_n = 1'b1;
    issue(0, 0, 32'h30, 32'h0, LW, 32'hCAFEF00D, 0);

    rr[0] = 1'b0;
    send(0, 1, 32'h34, 32'h11223344, LW, 32'h0, 0, 1'b0);
    wait_valid(0);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("drop");
    #2 reset_n = 1'b1;
    rr[0] = 1'b1;
    issue(0, 0, 32'h34, 32'h0, LW, 32'h11223344, 0);

    issue(1, 1, 32'h30, 32'h12345678, LW, 32'h0, 0);
    issue(1, 0, 32'h31, 32'h0, LBU, 32'h00000056, 0);
    issue(1, 0, 32'h32, 32'h0, LH, 32'h00001234, 0);
    issue(1, 0, 32'h33, 32'h0, LH, 32'h0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("q0_empty", q0.size(), 32'd0);
    chk("q1_empty", q1.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
